// File: rtl/updown_pkg.sv
// Shared encodings for the parametrised up/down counter: mode select and direction state.
package updown_pkg;

  typedef enum logic [1:0] {
    MODE_UP     = 2'b00,
    MODE_DOWN   = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/updown_next.sv
// Combinational step function: next count, direction and terminal-count flag for one
// enabled step, given the current state, mode, saturation select and limit.
module updown_next
  import updown_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] out,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             sat,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] next_out,
  output logic             next_dir,
  output logic             next_tc
);

  logic [WIDTH-1:0] w_one;
  logic [WIDTH-1:0] w_zero;

  assign w_one  = {{(WIDTH-1){1'b0}}, 1'b1};
  assign w_zero = '0;

  always_comb begin
    next_out = out;
    next_dir = dir;
    next_tc  = 1'b0;
    // Limit lowered below the count: pull back into range, nothing else this step.
    if (out > limit) begin
      next_out = limit;
    end else begin
      case (mode)
        MODE_UP: begin
          if (out == limit) begin
            next_tc  = 1'b1;
            next_out = sat ? limit : w_zero;
          end else begin
            next_out = out + w_one;
          end
        end
        MODE_DOWN: begin
          if (out == w_zero) begin
            next_tc  = 1'b1;
            next_out = sat ? w_zero : limit;
          end else begin
            next_out = out - w_one;
          end
        end
        MODE_BOUNCE: begin
          if (dir == DIR_UP) begin
            if (out == limit) begin
              next_dir = DIR_DOWN;
              next_tc  = 1'b1;
              next_out = (limit == w_zero) ? w_zero : limit - w_one;
            end else begin
              next_out = out + w_one;
            end
          end else begin
            if (out == w_zero) begin
              next_dir = DIR_UP;
              next_tc  = 1'b1;
              next_out = (limit == w_zero) ? w_zero : w_one;
            end else begin
              next_out = out - w_one;
            end
          end
        end
        default: begin
          next_out = out;
        end
      endcase
    end
  end

endmodule

// File: rtl/updown_cnt_gen.sv
// Parametrised up/down/bounce counter with enable, parallel load, wrap/saturate,
// runtime limit and a registered terminal-count pulse.
module updown_cnt_gen
  import updown_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [1:0]       mode,
  input  logic             sat,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] out,
  output logic             dir,
  output logic             tc
);

  logic [WIDTH-1:0] r_out;
  logic             r_dir;
  logic             r_tc;

  logic [WIDTH-1:0] w_next_out;
  logic             w_next_dir;
  logic             w_next_tc;
  logic [WIDTH-1:0] w_load_clamped;
  logic             w_bounce;

  assign w_load_clamped = (load_val > limit) ? limit : load_val;
  assign w_bounce       = (mode == MODE_BOUNCE);

  updown_next #(
    .WIDTH (WIDTH)
  ) u_next (
    .out      (r_out),
    .dir      (r_dir),
    .mode     (mode),
    .sat      (sat),
    .limit    (limit),
    .next_out (w_next_out),
    .next_dir (w_next_dir),
    .next_tc  (w_next_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out <= '0;
      r_dir <= DIR_UP;
      r_tc  <= 1'b0;
    end else if (load) begin
      r_out <= w_load_clamped;
      r_tc  <= 1'b0;
    end else begin
      // Outside bounce the direction is parked at UP so bounce always starts upward.
      if (en) begin
        r_out <= w_next_out;
        r_tc  <= w_next_tc;
        r_dir <= w_bounce ? w_next_dir : DIR_UP;
      end else begin
        r_tc  <= 1'b0;
        r_dir <= w_bounce ? r_dir : DIR_UP;
      end
    end
  end

  assign out = r_out;
  assign dir = r_dir;
  assign tc  = r_tc;

endmodule
